spi_slave_rx_tx: RTL and testbench

- SPI mode-0 responder (slave) for the 32-bit SPI master/initiator already in the design.
- Oversamples raw sclk, cs_n and mosi in the system clock domain. Shifts in one DATA_W-bit word MSB-first and shifts out a word latched at frame start on miso.
- Raises a one-cycle rx_valid strobe when a full word has arrived, equivalent to the master's trigger_out completion pulse.
- Sits at the pad side of a peripheral, opposite the master, in the same top-level SPI loopback.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_slave_rx_tx_if.sv | 27 ++
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_slave_rx_tx.sv | 143 ++++++++++++++
 tb/tb_spi_slave_rx_tx.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default frame width and the
// idle levels of the SPI lines, common to the master and this responder.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } spi_state_e;

    localparam int DEFAULT_DATA_W = 32;

    // Levels the lines rest at when no frame is in progress
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic CS_N_IDLE = 1'b1;
    localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_slave_rx_tx_if.sv
// SPI pad-side bundle. The master drives clock, select and data out; the
// responder drives miso and its tristate enable.
interface spi_slave_rx_tx_if;

    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (
        output sclk,
        output cs_n,
        output mosi,
        input  miso,
        input  miso_oe
    );

    modport slave (
        input  sclk,
        input  cs_n,
        input  mosi,
        output miso,
        output miso_oe
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for a raw asynchronous input, followed by one extra
// delayed copy used to produce single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    // Synchronizer chain plus the delayed copy, all resetting to the idle level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            dly_q  <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_o & ~dly_q;
    assign fall_o = ~sync_o & dly_q;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// SPI mode-0 responder. Oversamples the raw SPI lines in the system clock
// domain, receives one DATA_W-bit word MSB-first and returns a word latched
// when chip select falls.
module spi_slave_rx_tx
    import spi_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    spi_slave_rx_tx_if.slave  spi,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_ACTIVE = ACTIVE;
    localparam logic [1:0] S_DONE   = DONE;

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_n_s, cs_rise, cs_fall;
    logic mosi_s;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SCLK_IDLE)) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (spi.sclk),
        .sync_o (sclk_s),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CS_N_IDLE)) u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (spi.cs_n),
        .sync_o (cs_n_s),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // mosi only needs the same synchronizer depth so it lines up with sclk edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_sync_q <= {SYNC_STAGES{MOSI_IDLE}};
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
        end
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Frame sequencing; a chip-select release always takes priority over sclk edges
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    tx_shift_d = tx_data;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    state_d    = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (cs_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (bit_cnt_q == CNT_FULL) begin
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    state_d    = S_DONE;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                end else if (sclk_fall) begin
                    tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                end
            end
            S_DONE: begin
                if (cs_rise) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign spi.miso    = (state_q == S_ACTIVE) ? tx_shift_q[DATA_W-1] : 1'b0;
    assign spi.miso_oe = ~cs_n_s;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign busy        = (state_q == S_ACTIVE);

    // sclk level itself is not needed beyond its edges
    logic unused_sclk_s;
    assign unused_sclk_s = sclk_s;

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Directed bench for the SPI responder: a behavioural mode-0 master at
// sclk = clk/8, a scoreboard of expected received words, and strobe counters.
module tb_spi_slave_rx_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] txData;
    logic [31:0] rxData;
    logic        rxValid;
    logic        frameErr;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int lastRiseCycle = 0;
    int validCount = 0;
    int errCount = 0;
    logic [31:0] expQ[$];

    spi_slave_rx_tx_if spiBus ();

    spi_slave_rx_tx #(.DATA_W(32), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi       (spiBus),
        .tx_data   (txData),
        .rx_data   (rxData),
        .rx_valid  (rxValid),
        .frame_err (frameErr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Cycle counter used to measure rx_valid latency from the last raw sclk rise
    always @(posedge clk) cycle++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each rx_valid pops the next expected word and checks latency
    always @(negedge clk) begin
        if (rxValid === 1'b1) begin
            validCount++;
            if (expQ.size() == 0) begin
                tests++;
                fails++;
                $error("[TB] FAIL rx_unexpected observed=%h expected=no strobe", rxData);
            end else begin
                checkOutput("rx_word", rxData, expQ.pop_front());
                checkOutput("rx_latency", 32'(cycle - lastRiseCycle), 32'd4);
            end
        end
        if (frameErr === 1'b1) errCount++;
    end

    // One mode-0 bit: mosi set with sclk low, miso sampled just before the rise
    task automatic applyStimulus(input logic b, input bit markLast, output logic m);
        spiBus.mosi = b;
        repeat (4) @(negedge clk);
        m = spiBus.miso;
        spiBus.sclk = 1'b1;
        if (markLast) lastRiseCycle = cycle;
        repeat (4) @(negedge clk);
        spiBus.sclk = 1'b0;
    endtask

    // Whole frame of nbits pulses; bits past 32 carry ones. changeAt < 0 leaves tx_data alone.
    task automatic sendFrame(input logic [31:0] word, input int nbits, input int changeAt,
                             output logic [31:0] misoWord, output logic [3:0] extra);
        logic m;
        misoWord = '0;
        extra = '0;
        spiBus.cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == changeAt) txData = 32'h0;
            applyStimulus((i < 32) ? word[31-i] : 1'b1, i == 31, m);
            if (i < 32) misoWord[31-i] = m;
            else extra[i-32] = m;
        end
        repeat (4) @(negedge clk);
        spiBus.cs_n = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        logic [31:0] mw;
        logic [3:0]  ex;
        logic        m;
        int          vBase;

        rst = 1'b1;
        spiBus.sclk = 1'b0;
        spiBus.cs_n = 1'b1;
        spiBus.mosi = 1'b0;
        txData = 32'h5A5A5A5A;
        repeat (3) @(negedge clk);
        checkOutput("reset_rx_data", rxData, 32'h0);
        checkOutput("reset_rx_valid", 32'(rxValid), 32'h0);
        checkOutput("reset_frame_err", 32'(frameErr), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_miso", 32'(spiBus.miso), 32'h0);
        checkOutput("reset_miso_oe", 32'(spiBus.miso_oe), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame; also check busy/miso_oe while selected
        expQ.push_back(32'hA5A5A5A5);
        spiBus.cs_n = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("active_busy", 32'(busy), 32'h1);
        checkOutput("active_miso_oe", 32'(spiBus.miso_oe), 32'h1);
        spiBus.cs_n = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("abort_err_count", 32'(errCount), 32'd1);
        errCount = 0;
        sendFrame(32'hA5A5A5A5, 32, -1, mw, ex);
        checkOutput("basic_miso_word", mw, 32'h5A5A5A5A);
        checkOutput("basic_valid_count", 32'(validCount), 32'd1);
        checkOutput("basic_busy_after", 32'(busy), 32'h0);

        // Early chip-select release after 10 bits
        sendFrame(32'hFFFF0000, 10, -1, mw, ex);
        checkOutput("short_err_count", 32'(errCount), 32'd1);
        checkOutput("short_valid_count", 32'(validCount), 32'd1);
        checkOutput("short_rx_data_kept", rxData, 32'hA5A5A5A5);

        // Back-to-back frames
        expQ.push_back(32'h00000001);
        expQ.push_back(32'hFFFFFFFF);
        sendFrame(32'h00000001, 32, -1, mw, ex);
        checkOutput("b2b_busy_gap", 32'(busy), 32'h0);
        sendFrame(32'hFFFFFFFF, 32, -1, mw, ex);
        checkOutput("b2b_valid_count", 32'(validCount), 32'd3);

        // 36 pulses: extra bits ignored, miso quiet after the word
        expQ.push_back(32'h12345678);
        sendFrame(32'h12345678, 36, -1, mw, ex);
        checkOutput("long_miso_word", mw, 32'h5A5A5A5A);
        checkOutput("long_extra_miso", 32'(ex), 32'h0);
        checkOutput("long_valid_count", 32'(validCount), 32'd4);
        checkOutput("long_err_count", 32'(errCount), 32'd1);

        // Reset in the middle of a frame
        spiBus.cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, m);
        rst = 1'b1;
        spiBus.cs_n = 1'b1;
        #1;
        checkOutput("midrst_rx_data", rxData, 32'h0);
        checkOutput("midrst_busy", 32'(busy), 32'h0);
        checkOutput("midrst_miso_oe", 32'(spiBus.miso_oe), 32'h0);
        checkOutput("midrst_miso", 32'(spiBus.miso), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        vBase = validCount;
        expQ.push_back(32'hDEADBEEF);
        sendFrame(32'hDEADBEEF, 32, -1, mw, ex);
        checkOutput("postrst_valid_count", 32'(validCount - vBase), 32'd1);
        checkOutput("postrst_err_count", 32'(errCount), 32'd1);

        // tx_data changes mid-frame must not affect the word in flight
        txData = 32'hCAFEF00D;
        expQ.push_back(32'h0F0F0F0F);
        sendFrame(32'h0F0F0F0F, 32, 5, mw, ex);
        checkOutput("txchg_miso_word", mw, 32'hCAFEF00D);
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
